hazard_scoreboard: RTL

Register-hazard controller for the five-stage pipeline. Tracks in-flight register-file writes per destination register, stalls decode via `turn_off` when an issuing instruction reads or overflows a pending register, and retires entries when write-back asserts `reg_w` with `rw`. Provides a drain sequence so the pipeline can be emptied before a mode change or halt. Sits beside decode and takes its release inputs directly from the write-back stage outputs.

---
 rtl/hazard_scoreboard.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight register writes per destination,
// stalls decode on read-after-write or counter-full hazards, retires entries
// from write-back, and offers a drain sequence that empties the pipeline.
module hazard_scoreboard #(
    parameter int NREG = 16,
    parameter int AW   = 4,
    parameter int CW   = 2,
    parameter int SW   = 16
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            issue,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    input  logic            use_rs1,
    input  logic            use_rs2,
    input  logic [AW-1:0]   rd,
    input  logic            wr_rd,
    input  logic            kill,
    input  logic [AW-1:0]   wb_rw,
    input  logic            wb_reg_w,
    input  logic            drain_req,
    output logic            turn_off,
    output logic            issued,
    output logic            drain_done,
    output logic [NREG-1:0] busy,
    output logic [SW-1:0]   stall_cycles,
    output logic            err
);

    typedef enum logic {RUN, DRAIN} state_t;

    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [SW-1:0] SMAX = '1;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q [NREG];
    logic [CW-1:0]   count_d [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic            err_q, err_d;

    logic [CW-1:0]   eff [NREG];
    logic [NREG-1:0] inc;
    logic [NREG-1:0] dec;
    logic            haz;
    logic            all_eff_zero;

    // Effective counts see this cycle's write-back release, since the
    // register file writes before it reads; a release against an empty
    // counter is not a real release and leaves the count alone.
    always_comb begin
        all_eff_zero = 1'b1;
        for (int i = 0; i < NREG; i++) begin
            dec[i] = wb_reg_w && (wb_rw == AW'(i)) && (count_q[i] != '0);
            eff[i] = count_q[i] - {{(CW-1){1'b0}}, dec[i]};
            if (eff[i] != '0) all_eff_zero = 1'b0;
        end
    end

    // Hazard detection, stall/issue handshake and FSM next state.
    always_comb begin
        state_d    = state_q;
        turn_off   = 1'b0;
        issued     = 1'b0;
        drain_done = 1'b0;
        haz = issue && !kill &&
              ((use_rs1 && eff[rs1] != '0) ||
               (use_rs2 && eff[rs2] != '0) ||
               (wr_rd   && eff[rd] == CMAX));
        if (clear) begin
            case (state_q)
                RUN: begin
                    turn_off = haz;
                    issued   = issue && !kill && !haz;
                    if (drain_req) state_d = DRAIN;
                end
                DRAIN: begin
                    turn_off = issue;
                    if (all_eff_zero) begin
                        drain_done = 1'b1;
                        state_d    = RUN;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    // Per-register counter update, sticky error and stall-cycle counting.
    always_comb begin
        err_d   = err_q;
        stall_d = stall_q;
        for (int i = 0; i < NREG; i++) begin
            inc[i]     = issued && wr_rd && (rd == AW'(i));
            count_d[i] = count_q[i];
            if (inc[i] && !dec[i]) begin
                if (count_q[i] == CMAX) err_d = 1'b1;
                else count_d[i] = count_q[i] + 1'b1;
            end else if (dec[i] && !inc[i]) begin
                count_d[i] = count_q[i] - 1'b1;
            end
            busy_d[i] = (count_d[i] != '0);
        end
        if (wb_reg_w && count_q[wb_rw] == '0) err_d = 1'b1;
        if (turn_off && stall_q != SMAX) stall_d = stall_q + 1'b1;
    end

    // State registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clear) begin
            state_q <= RUN;
            busy_q  <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
            for (int i = 0; i < NREG; i++) count_q[i] <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            stall_q <= stall_d;
            err_q   <= err_d;
            for (int i = 0; i < NREG; i++) count_q[i] <= count_d[i];
        end
    end

    assign busy         = busy_q;
    assign stall_cycles = stall_q;
    assign err          = err_q;

endmodule
